// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module   : step_controller
// Purpose  : Generates a one-cycle CPU clock enable (cpu_en) for a 6502 core
//            running in the FPGA clock domain. A debounced push button
//            single-steps the core, a run switch selects free-running
//            execution at a divided rate, and a halt request from the core
//            stops issue until the button is pressed again.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEBOUNCE_CYCLES : stable cycles before a button level change is accepted
//                     (>= 1)
//   RUN_DIV         : clk cycles between cpu_en pulses in RUN mode (>= 2)
//   CNT_W           : width of step_count (only with STEP_COUNTER_EN)
// Ports
//   clk        in   FPGA system clock
//   rst        in   synchronous, active-high reset
//   btn_raw    in   raw step button (asynchronous, bouncy, active-high)
//   run_sel    in   mode switch (asynchronous): 0 single-step, 1 free-run
//   halt       in   synchronous halt request from the core (level)
//   cpu_en     out  registered one-cycle clock enable to the core
//   btn_clean  out  debounced button level
//   mode       out  current state: 00 STEP, 01 RUN, 10 HALTED
//   step_count out  number of cpu_en pulses issued (STEP_COUNTER_EN only)
// Configuration macro
//   STEP_COUNTER_EN : when defined, adds the CNT_W parameter, the step_count
//                     port and its wrapping pulse counter.
// ============================================================================
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000
`ifdef STEP_COUNTER_EN
    ,
    parameter int CNT_W           = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             run_sel,
    input  logic             halt,
    output logic             cpu_en,
    output logic             btn_clean,
    output logic [1:0]       mode
`ifdef STEP_COUNTER_EN
    ,
    output logic [CNT_W-1:0] step_count
`endif
);

    // Counter widths hold 0..N-1; a one-cycle debounce still needs one bit.
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = $clog2(RUN_DIV);

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous board inputs
    // ------------------------------------------------------------------------
    logic btn_meta_q, btn_s_q;
    logic run_meta_q, run_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_s_q    <= btn_meta_q;
            run_meta_q <= run_sel;
            run_s_q    <= run_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: the synchronized level must disagree with the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles before it is taken. Any cycle of
    // agreement restarts the count, so short glitches never get through.
    // ------------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q;
    logic            btn_clean_q;
    logic            btn_clean_dly_q;
    logic            btn_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q        <= '0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
        end else begin
            btn_clean_dly_q <= btn_clean_q;
            if (btn_s_q != btn_clean_q) begin
                if (db_cnt_q == DB_MAX) begin
                    btn_clean_q <= btn_s_q;
                    db_cnt_q    <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Only presses matter; releases are ignored.
    assign btn_rise = btn_clean_q & ~btn_clean_dly_q;

    // ------------------------------------------------------------------------
    // Mode FSM and run-rate divider
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_en_q, cpu_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STEP;
            div_q    <= '0;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_STEP: begin
                // halt wins over everything, then the run switch, then a press
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (run_s_q) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else begin
                    cpu_en_d = btn_rise;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                    div_d   = '0;
                end else if (!run_s_q) begin
                    state_d = ST_STEP;
                    div_d   = '0;
                end else if (div_q == DIV_MAX) begin
                    // Terminal count: the pulse lands in the following cycle,
                    // so the first one appears RUN_DIV cycles after entry.
                    cpu_en_d = 1'b1;
                    div_d    = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HALTED: begin
                div_d = '0;
                // The releasing press only resumes stepping; it issues nothing.
                if (btn_rise && !halt) begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_STEP;
                div_d   = '0;
            end
        endcase
    end

    assign cpu_en    = cpu_en_q;
    assign btn_clean = btn_clean_q;
    assign mode      = state_q;

`ifdef STEP_COUNTER_EN
    // ------------------------------------------------------------------------
    // Issued-pulse counter; wraps naturally and survives mode changes.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] step_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q <= '0;
        end else if (cpu_en_q) begin
            step_cnt_q <= step_cnt_q + CNT_W'(1);
        end
    end

    assign step_count = step_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_controller
// Purpose  : Self-checking bench for step_controller. Directed scenarios for
//            debounce timing, bounce rejection, RUN pacing, halt handling and
//            mid-run reset, followed by randomized stimulus. A behavioural
//            model (consecutive-mismatch debounce, cycles-since-RUN-entry
//            pacing) predicts every output each cycle.
//            Define STEP_COUNTER_EN to also exercise step_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_controller;

    localparam int TB_DB   = 4;
    localparam int TB_DIV  = 8;
    localparam int TB_CNTW = 4;

    logic clk = 1'b0;
    logic rst, btn_raw, run_sel, halt;
    logic cpu_en, btn_clean;
    logic [1:0] mode;
`ifdef STEP_COUNTER_EN
    logic [TB_CNTW-1:0] step_count;
`endif

    always #5 clk = ~clk;

    step_controller #(
        .DEBOUNCE_CYCLES (TB_DB),
        .RUN_DIV         (TB_DIV)
`ifdef STEP_COUNTER_EN
        ,
        .CNT_W           (TB_CNTW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .run_sel    (run_sel),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .btn_clean  (btn_clean)
        ,
        .mode       (mode)
`ifdef STEP_COUNTER_EN
        ,
        .step_count (step_count)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int n_pulses = 0;
    logic en_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. Mode: 0 STEP, 1 RUN, 2 HALTED.
    // m_mismatch = consecutive cycles the synchronized button disagreed with
    // the accepted level; m_age = cycles spent in RUN since entry.
    // ------------------------------------------------------------------------
    int m_pipe1, m_btn_s, m_rpipe1, m_run_s;
    int m_clean, m_clean_prev, m_mismatch;
    int m_mode, m_age, m_en, m_cnt;

    function automatic void model_edge();
        int rise, n_clean, n_mis, n_mode, n_age, n_en;
        if (rst) begin
            m_pipe1 = 0; m_btn_s = 0; m_rpipe1 = 0; m_run_s = 0;
            m_clean = 0; m_clean_prev = 0; m_mismatch = 0;
            m_mode = 0; m_age = 0; m_en = 0; m_cnt = 0;
            return;
        end
        rise    = (m_clean == 1 && m_clean_prev == 0) ? 1 : 0;
        n_clean = m_clean;
        n_mis   = 0;
        if (m_btn_s != m_clean) begin
            n_mis = m_mismatch + 1;
            if (n_mis == TB_DB) begin
                n_clean = m_btn_s;
                n_mis   = 0;
            end
        end
        n_mode = m_mode;
        n_age  = m_age;
        n_en   = 0;
        if (m_mode == 0) begin
            if (halt) n_mode = 2;
            else if (m_run_s == 1) begin n_mode = 1; n_age = 0; end
            else n_en = rise;
        end else if (m_mode == 1) begin
            if (halt) begin n_mode = 2; n_age = 0; end
            else if (m_run_s == 0) begin n_mode = 0; n_age = 0; end
            else begin
                n_age = m_age + 1;
                n_en  = (n_age % TB_DIV == 0) ? 1 : 0;
            end
        end else begin
            if (rise == 1 && !halt) n_mode = 0;
        end
        if (m_en == 1) m_cnt = (m_cnt + 1) % (1 << TB_CNTW);
        m_clean_prev = m_clean;
        m_clean      = n_clean;
        m_mismatch   = n_mis;
        m_btn_s      = m_pipe1;
        m_pipe1      = int'(btn_raw);
        m_run_s      = m_rpipe1;
        m_rpipe1     = int'(run_sel);
        m_mode       = n_mode;
        m_age        = n_age;
        m_en         = n_en;
    endfunction

    // One clock: model advances on the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cpu_en", 32'(cpu_en), m_en);
        check("btn_clean", 32'(btn_clean), m_clean);
        check("mode", 32'(mode), m_mode);
`ifdef STEP_COUNTER_EN
        check("step_count", 32'(step_count), m_cnt);
`endif
        check("en_back_to_back", 32'(en_prev & cpu_en), 0);
        en_prev = cpu_en;
        if (cpu_en) n_pulses++;
    endtask

    task automatic press(input int hold);
        btn_raw = 1'b1;
        repeat (hold) tick();
        btn_raw = 1'b0;
        repeat (hold) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin : stim
        int obs_clean [10];
        int obs_en [10];
        int p0, k, btn_left;
        bit found;

        rst = 1'b1; btn_raw = 1'b0; run_sel = 1'b0; halt = 1'b0;
        tick();
        check("reset_cpu_en", 32'(cpu_en), 0);
        check("reset_btn_clean", 32'(btn_clean), 0);
        check("reset_mode", 32'(mode), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Held press: accepted at edge 6, step pulse in the cycle after edge 7
        btn_raw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            obs_clean[i] = int'(btn_clean);
            obs_en[i]    = int'(cpu_en);
        end
        check("press_clean_e5", obs_clean[5], 0);
        check("press_clean_e6", obs_clean[6], 1);
        check("press_en_e6", obs_en[6], 0);
        check("press_en_e7", obs_en[7], 1);
        check("press_en_e8", obs_en[8], 0);
        check("press_mode", 32'(mode), 0);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Bounce shorter than the debounce window is rejected
        p0 = n_pulses;
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (btn_clean) found = 1'b1;
        end
        check("bounce_clean", 32'(found), 0);
        check("bounce_pulses", n_pulses - p0, 0);

        // RUN: one pulse per 8 cycles, presses ignored, stops on exit
        run_sel = 1'b1;
        k = 0;
        while (mode != 2'b01 && k < 10) begin tick(); k++; end
        check("run_entry", 32'(mode), 1);
        p0 = n_pulses;
        repeat (5) press(8);
        check("run_pulses_80", n_pulses - p0, 10);
        run_sel = 1'b0;
        p0 = n_pulses;
        repeat (20) tick();
        check("run_exit_mode", 32'(mode), 0);
        check("run_exit_pulses", n_pulses - p0, 0);

        // Halt on the terminal divider cycle
        run_sel = 1'b1;
        k = 0;
        while (!(m_mode == 1 && (m_age % TB_DIV) == 7) && k < 30) begin tick(); k++; end
        check("wait_div7", 32'(m_mode == 1 && (m_age % TB_DIV) == 7), 1);
        halt = 1'b1;
        tick();
        check("halt_en", 32'(cpu_en), 0);
        check("halt_mode", 32'(mode), 2);
        p0 = n_pulses;
        press(8);
        check("halt_press_mode", 32'(mode), 2);
        run_sel = 1'b0;
        halt = 1'b0;
        repeat (3) tick();
        press(8);
        check("unhalt_mode", 32'(mode), 0);
        check("unhalt_pulses", n_pulses - p0, 0);
        p0 = n_pulses;
        press(8);
        check("post_halt_step", n_pulses - p0, 1);

        // Reset mid-RUN with divider at 5
        run_sel = 1'b1;
        k = 0;
        while (!(m_mode == 1 && (m_age % TB_DIV) == 5) && k < 30) begin tick(); k++; end
        check("wait_div5", 32'(m_mode == 1 && (m_age % TB_DIV) == 5), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_en", 32'(cpu_en), 0);
        check("midrst_clean", 32'(btn_clean), 0);
        check("midrst_mode", 32'(mode), 0);
        k = 0;
        while (mode != 2'b01 && k < 10) begin tick(); k++; end
        check("rerun_entry", 32'(mode), 1);
        k = 0;
        found = 1'b0;
        while (!found && k < 30) begin
            tick();
            k++;
            if (cpu_en) found = 1'b1;
        end
        check("rerun_first_pulse", k, 8);
        run_sel = 1'b0;
        repeat (5) tick();

`ifdef STEP_COUNTER_EN
        do_reset();
        repeat (2) tick();
        for (int i = 0; i < 17; i++) press(8);
        check("count_wrap17", 32'(step_count), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("count_reset", 32'(step_count), 0);
`endif

        // Randomized traffic
        do_reset();
        btn_left = 1;
        for (int i = 0; i < 2500; i++) begin
            btn_left--;
            if (btn_left <= 0) begin
                btn_raw  = ~btn_raw;
                btn_left = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 39) == 0) run_sel = ~run_sel;
            if ($urandom_range(0, 29) == 0) halt = ~halt;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        halt = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
